// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: hilo operation codes,
// status bit positions and the packed result-entry width.
package alu_pkg;

  localparam int HILO_NONE = 0;
  localparam int HILO_MULT = 1;
  localparam int HILO_MTHI = 2;
  localparam int HILO_MTLO = 3;
  localparam int HILO_MFHI = 4;
  localparam int HILO_MFLO = 5;

  localparam int ST_ZERO  = 0;
  localparam int ST_NEG   = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_CARRY = 3;

  // Entry layout: {data, rd, we, excp}
  function automatic int entry_w(input int data_w, input int addr_w);
    return data_w + addr_w + 2;
  endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry in-order valid/ready buffer. The head slot drives the output
// directly; inReady is a registered copy of "fewer than two entries held".
module result_skid_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             ready_q;
  logic             push, pop;

  assign push        = in_valid_i & ready_q;
  assign pop         = (count_q != 2'd0) & out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;

  // Next-state: a pop shifts the tail forward, a push lands in the first free slot
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = tail_q;
    end
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        head_d = in_data_i;
      end else begin
        tail_d = in_data_i;
      end
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, occupancy and registered ready; reset discards all entries
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      ready_q <= 1'b1;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU writeback stage: holds architectural HI/LO, resolves MFHI/MFLO,
// applies overflow-trap write suppression and queues results for the
// register file through a two-entry skid buffer.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int STATUS_WIDTH = 4,
  parameter int REG_ADDR_W   = 5,
  parameter int HILO_OP_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [HILO_OP_W-1:0]    hiloOp,
  input  logic [DATA_WIDTH-1:0]   aluData,
  input  logic [DATA_WIDTH-1:0]   aluHi,
  input  logic [DATA_WIDTH-1:0]   aluLo,
  input  logic [STATUS_WIDTH-1:0] aluStatus,
  input  logic                    trapOvf,
  input  logic [REG_ADDR_W-1:0]   rdAddr,
  input  logic                    regWe,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [DATA_WIDTH-1:0]   outData,
  output logic [REG_ADDR_W-1:0]   outRd,
  output logic                    outWe,
  output logic                    outExcp,
  output logic [DATA_WIDTH-1:0]   hiReg,
  output logic [DATA_WIDTH-1:0]   loReg
);

  localparam int ENTRY_W = entry_w(DATA_WIDTH, REG_ADDR_W);

  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  accept, trap;
  logic                  op_mult, op_mthi, op_mtlo, op_mfhi, op_mflo;
  logic [DATA_WIDTH-1:0] entry_data;
  logic                  entry_we;
  logic [ENTRY_W-1:0]    entry_in, entry_out;
  logic                  unused_status;

  // Only the overflow flag matters here; the other status bits pass through unused
  assign unused_status = ^aluStatus;

  assign accept  = inValid & inReady;
  assign trap    = trapOvf & aluStatus[ST_OVF];
  assign op_mult = (hiloOp == HILO_OP_W'(HILO_MULT));
  assign op_mthi = (hiloOp == HILO_OP_W'(HILO_MTHI));
  assign op_mtlo = (hiloOp == HILO_OP_W'(HILO_MTLO));
  assign op_mfhi = (hiloOp == HILO_OP_W'(HILO_MFHI));
  assign op_mflo = (hiloOp == HILO_OP_W'(HILO_MFLO));

  // Moves-from read the pre-edge HI/LO, so a MULT one cycle earlier is already visible
  assign entry_data = op_mfhi ? hi_q : (op_mflo ? lo_q : aluData);
  assign entry_we   = regWe & ~trap & (rdAddr != '0);
  assign entry_in   = {entry_data, rdAddr, entry_we, trap};

  // HI/LO next state; a trapped instruction leaves them untouched
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept && !trap) begin
      if (op_mult) begin
        hi_d = aluHi;
        lo_d = aluLo;
      end
      if (op_mthi) hi_d = aluData;
      if (op_mtlo) lo_d = aluData;
    end
  end

  // Architectural HI/LO registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  result_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_data_i   (entry_in),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_data_o  (entry_out)
  );

  assign {outData, outRd, outWe, outExcp} = entry_out;
  assign hiReg = hi_q;
  assign loReg = lo_q;

endmodule
